adder_share_arb: RTL and testbench

- Arbitrates two requesters onto one shared registered adder, of the same kind as the team's 4-bit registered adder.
- Round-robin grant. Latches the winner's operands and drives them to the adder. Waits a fixed adder latency, captures the sum and returns it with a one-cycle ack.
- Sits between client logic and the adder datapath; the adder instance is external.

---
 rtl/adder_share_arb_if.sv | 43 ++++
 rtl/adder_share_arb.sv | 162 ++++++++++++++++
 tb/tb_adder_share_arb.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/adder_share_arb_if.sv
// ---------------------------------------------------------------------------
// adder_share_arb_if
// Bundles the client request/operand/result signals and the shared-adder
// operand/result signals of the adder arbiter.
//
//   req0/a0/b0, req1/a1/b1 : requester level requests and operands
//   gnt, ack, res, busy    : one-hot grant, one-cycle ack, result, busy flag
//   add_a/add_b/add_go     : operands and operand-valid strobe to the adder
//   add_res                : result returned by the external adder
//
// Modports:
//   slave  : the arbiter side (consumes requests, drives grants/adder ops)
//   master : the environment side (clients plus the adder instance)
// ---------------------------------------------------------------------------
interface adder_share_arb_if #(
  parameter int DW = 4,
  parameter int RW = 8
);
  logic          req0;
  logic [DW-1:0] a0;
  logic [DW-1:0] b0;
  logic          req1;
  logic [DW-1:0] a1;
  logic [DW-1:0] b1;
  logic [1:0]    gnt;
  logic [1:0]    ack;
  logic [RW-1:0] res;
  logic          busy;
  logic [DW-1:0] add_a;
  logic [DW-1:0] add_b;
  logic          add_go;
  logic [RW-1:0] add_res;

  modport slave (
    input  req0, a0, b0, req1, a1, b1, add_res,
    output gnt, ack, res, busy, add_a, add_b, add_go
  );

  modport master (
    output req0, a0, b0, req1, a1, b1, add_res,
    input  gnt, ack, res, busy, add_a, add_b, add_go
  );
endinterface

// File: rtl/adder_share_arb.sv
// ---------------------------------------------------------------------------
// adder_share_arb
// Round-robin arbiter that shares one external registered adder between two
// requesters. The winner's operands are latched and presented to the adder
// for one cycle (add_go), the arbiter waits LAT cycles, captures the adder
// result and returns it with a one-cycle one-hot ack.
//
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : adder_share_arb_if.slave
//            req0/a0/b0, req1/a1/b1 in  - level requests and operands
//            gnt[1:0]              out - one-hot grant
//            ack[1:0]              out - one-hot completion pulse
//            res[RW-1:0]           out - result, valid with ack, held after
//            busy                  out - high whenever not IDLE
//            add_a/add_b           out - operands to the adder
//            add_go                out - operand strobe, ISSUE cycle only
//            add_res[RW-1:0]       in  - adder result
//
// Parameters: DW operand width, RW result width (>= DW+1), LAT adder
// latency in cycles (>= 1). All outputs come straight from flops.
// ---------------------------------------------------------------------------
module adder_share_arb #(
  parameter int DW  = 4,
  parameter int RW  = 8,
  parameter int LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  adder_share_arb_if.slave  bus
);

  localparam int CW = $clog2(LAT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    gnt_q, gnt_d;
  logic [1:0]    ack_q, ack_d;
  logic [RW-1:0] res_q, res_d;
  logic          busy_q, busy_d;
  logic [DW-1:0] add_a_q, add_a_d;
  logic [DW-1:0] add_b_q, add_b_d;
  logic          add_go_q, add_go_d;
  logic [CW-1:0] cnt_q, cnt_d;
  // 0: requester 0 preferred on a tie, 1: requester 1 preferred
  logic          pref_q, pref_d;

  logic          win1;

  // Requester 1 wins when it is the only one asking, or on a tie when it
  // holds the round-robin preference.
  always_comb begin
    win1 = bus.req1 & (~bus.req0 | pref_q);
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    ack_d    = 2'b00;
    res_d    = res_q;
    add_a_d  = add_a_q;
    add_b_d  = add_b_q;
    add_go_d = 1'b0;
    cnt_d    = cnt_q;
    pref_d   = pref_q;

    case (state_q)
      S_IDLE: begin
        if (bus.req0 | bus.req1) begin
          state_d  = S_ISSUE;
          gnt_d    = win1 ? 2'b10 : 2'b01;
          add_a_d  = win1 ? bus.a1 : bus.a0;
          add_b_d  = win1 ? bus.b1 : bus.b0;
          // add_go is registered, so it is raised on the edge entering ISSUE
          add_go_d = 1'b1;
        end
      end

      S_ISSUE: begin
        cnt_d   = CW'(LAT);
        state_d = S_WAIT;
      end

      S_WAIT: begin
        cnt_d = cnt_q - CW'(1);
        // Only the final WAIT cycle carries a valid adder result.
        if (cnt_q == CW'(1)) begin
          res_d   = bus.add_res;
          ack_d   = gnt_q;
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        // Hand preference to whichever requester was not just served.
        pref_d  = gnt_q[0];
        gnt_d   = 2'b00;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        gnt_d   = 2'b00;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      gnt_q    <= 2'b00;
      ack_q    <= 2'b00;
      res_q    <= '0;
      busy_q   <= 1'b0;
      add_a_q  <= '0;
      add_b_q  <= '0;
      add_go_q <= 1'b0;
      cnt_q    <= '0;
      pref_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      ack_q    <= ack_d;
      res_q    <= res_d;
      busy_q   <= busy_d;
      add_a_q  <= add_a_d;
      add_b_q  <= add_b_d;
      add_go_q <= add_go_d;
      cnt_q    <= cnt_d;
      pref_q   <= pref_d;
    end
  end

  assign bus.gnt    = gnt_q;
  assign bus.ack    = ack_q;
  assign bus.res    = res_q;
  assign bus.busy   = busy_q;
  assign bus.add_a  = add_a_q;
  assign bus.add_b  = add_b_q;
  assign bus.add_go = add_go_q;

`ifndef SYNTHESIS
  a_gnt_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(gnt_q));
  a_ack_in_done: assert property (@(posedge clk) disable iff (!rst_n)
    (ack_q != 2'b00) |-> (state_q == S_DONE));
  a_go_in_issue: assert property (@(posedge clk) disable iff (!rst_n)
    add_go_q |-> (state_q == S_ISSUE));
  a_ack_has_gnt: assert property (@(posedge clk) disable iff (!rst_n)
    (ack_q & ~gnt_q) == 2'b00);
`endif

endmodule

// File: tb/tb_adder_share_arb.sv
// ---------------------------------------------------------------------------
// tb_adder_share_arb
// Bench for adder_share_arb. u_lat1 (LAT=1) is paired with a registered
// adder model and a per-requester scoreboard of expected sums; u_lat3
// (LAT=3) gets its add_res driven directly to exercise mid-WAIT reset and
// last-WAIT-cycle capture. Inputs change and outputs are sampled on the
// falling clock edge.
// ---------------------------------------------------------------------------
module tb_adder_share_arb;
  localparam int DW = 4;
  localparam int RW = 8;

  logic clk = 1'b0;
  logic rst_n1 = 1'b0;
  logic rst_n3 = 1'b0;

  always #5 clk = ~clk;

  adder_share_arb_if #(.DW(DW), .RW(RW)) if1 ();
  adder_share_arb_if #(.DW(DW), .RW(RW)) if3 ();

  adder_share_arb #(.DW(DW), .RW(RW), .LAT(1)) u_lat1 (
    .clk   (clk),
    .rst_n (rst_n1),
    .bus   (if1)
  );

  adder_share_arb #(.DW(DW), .RW(RW), .LAT(3)) u_lat3 (
    .clk   (clk),
    .rst_n (rst_n3),
    .bus   (if3)
  );

  // Registered adder attached to u_lat1.
  always @(posedge clk) if1.add_res <= RW'(if1.add_a) + RW'(if1.add_b);

  int n_chk  = 0;
  int n_pass = 0;

  logic [RW-1:0] exp_q0[$];
  logic [RW-1:0] exp_q1[$];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, act, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Scoreboard: every ack from u_lat1 pops the acked requester's queue.
  always @(negedge clk) begin
    if (rst_n1 && if1.ack != 2'b00) begin
      if (if1.ack == 2'b01) begin
        if (exp_q0.size() == 0) check_eq("sb_unexpected_ack0", 32'(if1.ack), 32'h0);
        else check_eq("sb_res0", 32'(if1.res), 32'(exp_q0.pop_front()));
      end else if (if1.ack == 2'b10) begin
        if (exp_q1.size() == 0) check_eq("sb_unexpected_ack1", 32'(if1.ack), 32'h0);
        else check_eq("sb_res1", 32'(if1.res), 32'(exp_q1.pop_front()));
      end else begin
        check_eq("sb_ack_onehot", 32'(if1.ack), 32'h1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int  served;
    int  exp_id;
    int  id;
    bit  pend0, pend1;
    bit  saw_ack;
    bit  saw_busy;

    // Reset with random inputs
    if1.req0 = 1'($urandom); if1.a0 = 4'($urandom); if1.b0 = 4'($urandom);
    if1.req1 = 1'($urandom); if1.a1 = 4'($urandom); if1.b1 = 4'($urandom);
    if3.req0 = 1'($urandom); if3.a0 = 4'($urandom); if3.b0 = 4'($urandom);
    if3.req1 = 1'($urandom); if3.a1 = 4'($urandom); if3.b1 = 4'($urandom);
    if3.add_res = 8'($urandom);
    repeat (3) tick();
    check_eq("rst_gnt",    32'(if1.gnt),    32'h0);
    check_eq("rst_ack",    32'(if1.ack),    32'h0);
    check_eq("rst_add_go", 32'(if1.add_go), 32'h0);
    check_eq("rst_busy",   32'(if1.busy),   32'h0);
    check_eq("rst_res",    32'(if1.res),    32'h0);
    check_eq("rst_add_a",  32'(if1.add_a),  32'h0);
    check_eq("rst_add_b",  32'(if1.add_b),  32'h0);
    check_eq("rst3_gnt",   32'(if3.gnt),    32'h0);
    check_eq("rst3_busy",  32'(if3.busy),   32'h0);
    check_eq("rst3_res",   32'(if3.res),    32'h0);
    if1.req0 = 1'b0; if1.req1 = 1'b0; if1.a1 = '0; if1.b1 = '0;
    if3.req0 = 1'b0; if3.req1 = 1'b0; if3.add_res = '0;
    rst_n1 = 1'b1;
    rst_n3 = 1'b1;
    tick();

    // Single request, LAT=1: 3+5
    if1.a0 = 4'd3; if1.b0 = 4'd5; if1.req0 = 1'b1;
    exp_q0.push_back(8'd8);
    tick();
    check_eq("t1_gnt_c1",    32'(if1.gnt),    32'h1);
    check_eq("t1_go_c1",     32'(if1.add_go), 32'h1);
    check_eq("t1_add_a_c1",  32'(if1.add_a),  32'h3);
    check_eq("t1_add_b_c1",  32'(if1.add_b),  32'h5);
    tick();
    check_eq("t1_go_c2",     32'(if1.add_go), 32'h0);
    check_eq("t1_busy_c2",   32'(if1.busy),   32'h1);
    check_eq("t1_ack_c2",    32'(if1.ack),    32'h0);
    tick();
    check_eq("t1_ack_c3",    32'(if1.ack),    32'h1);
    check_eq("t1_busy_c3",   32'(if1.busy),   32'h1);
    if1.req0 = 1'b0;
    tick();
    check_eq("t1_busy_c4",   32'(if1.busy),   32'h0);
    check_eq("t1_gnt_c4",    32'(if1.gnt),    32'h0);
    check_eq("t1_ack_c4",    32'(if1.ack),    32'h0);
    check_eq("t1_res_hold",  32'(if1.res),    32'h8);

    // Simultaneous requests straight after reset
    rst_n1 = 1'b0;
    tick();
    rst_n1 = 1'b1;
    if1.a0 = 4'd15; if1.b0 = 4'd15; if1.req0 = 1'b1;
    if1.a1 = 4'd1;  if1.b1 = 4'd2;  if1.req1 = 1'b1;
    exp_q0.push_back(8'h1E);
    exp_q1.push_back(8'h03);
    tick();
    check_eq("t2_gnt_c1",   32'(if1.gnt),   32'h1);
    repeat (2) tick();
    check_eq("t2_ack_c3",   32'(if1.ack),   32'h1);
    if1.req0 = 1'b0;
    tick();
    check_eq("t2_gnt_c4",   32'(if1.gnt),   32'h0);
    check_eq("t2_busy_c4",  32'(if1.busy),  32'h0);
    tick();
    check_eq("t2_gnt_c5",   32'(if1.gnt),   32'h2);
    check_eq("t2_add_a_c5", 32'(if1.add_a), 32'h1);
    check_eq("t2_add_b_c5", 32'(if1.add_b), 32'h2);
    repeat (2) tick();
    check_eq("t2_ack_c7",   32'(if1.ack),   32'h2);
    if1.req1 = 1'b0;
    tick();

    // Fairness: both requesters re-raise the cycle after each ack
    rst_n1 = 1'b0;
    tick();
    rst_n1 = 1'b1;
    if1.a0 = 4'($urandom_range(0, 15)); if1.b0 = 4'($urandom_range(0, 15)); if1.req0 = 1'b1;
    exp_q0.push_back(RW'(if1.a0) + RW'(if1.b0));
    if1.a1 = 4'($urandom_range(0, 15)); if1.b1 = 4'($urandom_range(0, 15)); if1.req1 = 1'b1;
    exp_q1.push_back(RW'(if1.a1) + RW'(if1.b1));
    served = 0; exp_id = 0; pend0 = 1'b0; pend1 = 1'b0;
    for (int c = 0; c < 400 && served < 9; c++) begin
      tick();
      if (pend0) begin
        if1.a0 = 4'($urandom_range(0, 15)); if1.b0 = 4'($urandom_range(0, 15)); if1.req0 = 1'b1;
        exp_q0.push_back(RW'(if1.a0) + RW'(if1.b0));
        pend0 = 1'b0;
      end
      if (pend1) begin
        if1.a1 = 4'($urandom_range(0, 15)); if1.b1 = 4'($urandom_range(0, 15)); if1.req1 = 1'b1;
        exp_q1.push_back(RW'(if1.a1) + RW'(if1.b1));
        pend1 = 1'b0;
      end
      if (if1.ack != 2'b00) begin
        id = if1.ack[1] ? 1 : 0;
        check_eq("fair_order", 32'(id), 32'(exp_id));
        exp_id = exp_id ^ 1;
        served++;
        if (id == 0) begin if1.req0 = 1'b0; pend0 = (served < 8); end
        else         begin if1.req1 = 1'b0; pend1 = (served < 8); end
      end
    end
    check_eq("fair_count", 32'(served), 32'd9);
    repeat (2) tick();
    check_eq("sb_drain0", 32'(exp_q0.size()), 32'd0);
    check_eq("sb_drain1", 32'(exp_q1.size()), 32'd0);

    // Reset in the middle of WAIT, LAT=3
    if3.a0 = 4'd7; if3.b0 = 4'd2; if3.req0 = 1'b1;
    tick();
    check_eq("t4_gnt_c1",  32'(if3.gnt),    32'h1);
    check_eq("t4_go_c1",   32'(if3.add_go), 32'h1);
    tick();
    check_eq("t4_busy_c2", 32'(if3.busy),   32'h1);
    tick();
    rst_n3 = 1'b0;
    #1;
    check_eq("t4_rst_gnt",  32'(if3.gnt),  32'h0);
    check_eq("t4_rst_busy", 32'(if3.busy), 32'h0);
    check_eq("t4_rst_ack",  32'(if3.ack),  32'h0);
    if3.req0 = 1'b0;
    tick();
    rst_n3 = 1'b1;
    saw_ack = 1'b0; saw_busy = 1'b0;
    repeat (6) begin
      tick();
      if (if3.ack != 2'b00) saw_ack = 1'b1;
      if (if3.busy) saw_busy = 1'b1;
    end
    check_eq("t4_no_ack_after_rst",  32'(saw_ack),  32'h0);
    check_eq("t4_no_busy_after_rst", 32'(saw_busy), 32'h0);

    // LAT=3 with garbage on add_res outside the last WAIT cycle
    if3.a0 = 4'd1; if3.b0 = 4'd1; if3.req0 = 1'b1;
    if3.a1 = 4'd2; if3.b1 = 4'd2; if3.req1 = 1'b1;
    if3.add_res = 8'hA5;
    tick();
    check_eq("t5_gnt_c1",   32'(if3.gnt),    32'h1);
    check_eq("t5_go_c1",    32'(if3.add_go), 32'h1);
    check_eq("t5_add_a_c1", 32'(if3.add_a),  32'h1);
    if3.add_res = 8'h5A;
    tick();
    check_eq("t5_go_c2",  32'(if3.add_go), 32'h0);
    check_eq("t5_ack_c2", 32'(if3.ack),    32'h0);
    if3.add_res = 8'hFF;
    tick();
    check_eq("t5_ack_c3", 32'(if3.ack), 32'h0);
    if3.add_res = 8'hC3;
    tick();
    check_eq("t5_ack_c4", 32'(if3.ack), 32'h0);
    if3.add_res = 8'h02;
    tick();
    check_eq("t5_ack_c5",    32'(if3.ack),   32'h1);
    check_eq("t5_res_c5",    32'(if3.res),   32'h02);
    check_eq("t5_add_a_hold", 32'(if3.add_a), 32'h1);
    check_eq("t5_add_b_hold", 32'(if3.add_b), 32'h1);
    if3.add_res = 8'h77;
    if3.req0 = 1'b0;
    if3.req1 = 1'b0;
    tick();
    check_eq("t5_busy_c6", 32'(if3.busy), 32'h0);
    check_eq("t5_ack_c6",  32'(if3.ack),  32'h0);
    check_eq("t5_res_c6",  32'(if3.res),  32'h02);
    tick();
    check_eq("t5_gnt_c7",  32'(if3.gnt),  32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
